// File: rtl/cic_upsampler.sv
// Zero-insertion rate expander between the CIC comb and integrator chains.
// Optional build macro CIC_UPSAMPLE_HOLD_EN: fill slots repeat the last sample instead of zero.
module cic_upsampler #(
    parameter int DATA_W = 32,
    parameter int RATE   = 8,
    parameter int PH_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic [PH_W-1:0]          out_phase,
    output logic                     underrun
);

    // state | meaning
    // IDLE  | no stream yet (or flushed); outputs held at zero, waiting for a sample
    // RUN   | one output per clock; phase 0 carries a popped sample, other phases fill
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATE - 1);

    state_t                   state;
    logic signed [DATA_W-1:0] fifo_mem [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic [PH_W-1:0]          phase;   // phase of the next slot to be emitted

    logic                     push;
    logic                     pop;
    logic                     slot_zero;
    logic [PH_W-1:0]          phase_nxt;
    logic signed [DATA_W-1:0] head;
    logic signed [DATA_W-1:0] fill;

`ifdef CIC_UPSAMPLE_HOLD_EN
    logic signed [DATA_W-1:0] last;
`endif

    always_comb begin
        in_ready  = (count != 2'd2);
        push      = in_valid && in_ready;
        // phase is always 0 while in IDLE, so one test covers both start-up and phase-0 slots
        slot_zero = (phase == '0);
        pop       = (count != 2'd0) && slot_zero;
        phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
        head      = fifo_mem[rd_ptr];
`ifdef CIC_UPSAMPLE_HOLD_EN
        fill      = last;
`else
        fill      = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            phase     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_phase <= '0;
            underrun  <= 1'b0;
`ifdef CIC_UPSAMPLE_HOLD_EN
            last      <= '0;
`endif
        end else if (flush) begin
            // underrun is deliberately kept so a flush cannot hide a past starvation event
            state     <= IDLE;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            phase     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_phase <= '0;
`ifdef CIC_UPSAMPLE_HOLD_EN
            last      <= '0;
`endif
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
`ifdef CIC_UPSAMPLE_HOLD_EN
                last   <= head;
`endif
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (pop) begin
                        out_data  <= head;
                        out_valid <= 1'b1;
                        out_phase <= '0;
                        phase     <= phase_nxt;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    out_phase <= phase;
                    phase     <= phase_nxt;
                    if (pop) begin
                        out_data <= head;
                    end else begin
                        out_data <= fill;
                        if (slot_zero) begin
                            underrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
